// File: rtl/mdu_hilo.sv
// mdu_hilo: 32-bit HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise divide requests are ignored.
module mdu_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;
  logic [5:0] cnt;
  logic [31:0] a, abs_a, abs_b, p_init, res_hi, res_lo;
  logic [63:0] p, p_next, prod, mul_step;
  logic [32:0] sum;
  logic neg_q, sgn, accept, take;
  assign sgn = ~op[0];
  assign abs_a = (sgn & rs_data[31]) ? -rs_data : rs_data;
  assign abs_b = (sgn & rt_data[31]) ? -rt_data : rt_data;
  assign take = state == IDLE && accept;
  assign busy = state != IDLE;
  assign sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, a} : 33'd0);
  assign mul_step = {sum, p[31:1]};
  assign prod = neg_q ? -p : p;
`ifdef MDU_DIV_EN
  logic [31:0] b;
  logic [32:0] t;
  logic [33:0] d;
  logic is_div, neg_r;
  assign accept = start;
  assign p_init = op[1] ? abs_a : abs_b;
  // Remainder lives in p[63:32], quotient bits shift into p[31:0].
  assign t = {p[63:32], p[31]};
  assign d = {1'b0, t} - {2'b0, b};
  assign p_next = !is_div ? mul_step
                : d[33] ? {t[31:0], p[30:0], 1'b0} : {d[31:0], p[30:0], 1'b1};
  assign res_hi = !is_div ? prod[63:32]
                : b == 32'd0 ? (neg_r ? -a : a)
                : neg_r ? -p[63:32] : p[63:32];
  assign res_lo = !is_div ? prod[31:0]
                : b == 32'd0 ? 32'hffff_ffff
                : neg_q ? -p[31:0] : p[31:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      b <= '0;
      is_div <= 1'b0;
      neg_r <= 1'b0;
    end else if (take) begin
      b <= abs_b;
      is_div <= op[1];
      neg_r <= sgn & rs_data[31];
    end
  end
`else
  assign accept = start & ~op[1];
  assign p_init = abs_b;
  assign p_next = mul_step;
  assign res_hi = prod[63:32];
  assign res_lo = prod[31:0];
`endif
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (accept ? RUN : IDLE)
               : state == RUN ? (cnt == 6'd31 ? FIX : RUN)
               : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      cnt <= '0;
      a <= '0;
      p <= '0;
      neg_q <= 1'b0;
    end else begin
      state <= state_next;
      done <= state == FIX;
      if (take) begin
        a <= abs_a;
        p <= {32'd0, p_init};
        neg_q <= sgn & (rs_data[31] ^ rt_data[31]);
        cnt <= '0;
      end else if (state == IDLE) begin
        if (mthi) hi <= rs_data;
        if (mtlo) lo <= rs_data;
      end
      if (state == RUN) begin
        p <= p_next;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: vector table, corner sequences and randomized model checks for mdu_hilo.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst, start, mthi, mtlo, busy, done;
  logic [1:0] op;
  logic [31:0] rs_data, rt_data, hi, lo;
  int checks = 0;
  int errors = 0;

  mdu_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (o == 2'd0) return 64'(sa * sb);
    if (o == 2'd1) return 64'(ua * ub);
    if (b == 32'd0) return {a, 32'hffff_ffff};
    if (o == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int intr, input logic mt, output logic [63:0] res);
    int n;
    logic bz;
    start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mt; mtlo = mt;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
    bz = busy;
    n = 0;
    while (!done && n < 40) begin
      start = (n == intr); mthi = (n == intr); mtlo = (n == intr);
      if (n == intr) op = 2'($urandom);
      tick();
      n++;
      if (n < 33 && !busy) bz = 1'b0;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("latency", 64'(n), 64'd33);
    check("busy_run", 64'(bz), 64'd1);
    check("busy_end", 64'(busy), 64'd0);
    res = {hi, lo};
    tick();
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    vec_t tbl[$];
    logic [63:0] res, held;
    logic [31:0] ra, rb;
    logic [1:0] ro;
    logic bad;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
    tbl.push_back('{2'd1, 32'hffff_ffff, 32'hffff_ffff, 64'hffff_fffe_0000_0001});
    tbl.push_back('{2'd0, 32'hffff_fffd, 32'h0000_0005, 64'hffff_ffff_ffff_fff1});
    tbl.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    tbl.push_back('{2'd1, 32'h0000_0000, 32'h0001_2345, 64'h0});
    tbl.push_back('{2'd0, 32'hffff_ffff, 32'hffff_ffff, 64'h0000_0000_0000_0001});
    tbl.push_back('{2'd0, 32'h7fff_ffff, 32'h0000_0002, 64'h0000_0000_ffff_fffe});
`ifdef MDU_DIV_EN
    tbl.push_back('{2'd2, 32'hffff_fff9, 32'h0000_0002, 64'hffff_ffff_ffff_fffd});
    tbl.push_back('{2'd3, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_ffff_ffff});
    tbl.push_back('{2'd2, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000});
    tbl.push_back('{2'd2, 32'hffff_fffb, 32'h0000_0000, 64'hffff_fffb_ffff_ffff});
    tbl.push_back('{2'd3, 32'hffff_ffff, 32'h0000_0010, 64'h0000_000f_0fff_ffff});
    tbl.push_back('{2'd2, 32'h0000_0007, 32'hffff_fffe, 64'h0000_0001_ffff_fffd});
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy_done", {62'd0, busy, done}, 64'h0);
    // Idle register writes
    rs_data = 32'h1234_5678; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    check("mthi", {hi, lo}, 64'h1234_5678_0000_0000);
    check("mthi_flags", {62'd0, busy, done}, 64'h0);
    rs_data = 32'h0bad_cafe; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check("mtlo", {hi, lo}, 64'h1234_5678_0bad_cafe);
    rs_data = 32'ha5a5_a5a5; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'ha5a5_a5a5_a5a5_a5a5);
    check("mt_flags", {62'd0, busy, done}, 64'h0);
    foreach (tbl[i]) begin
      run_op(tbl[i].o, tbl[i].a, tbl[i].b, -1, 1'b0, res);
      check($sformatf("vec%0d", i), res, tbl[i].exp);
    end
    // Start and register writes while busy are ignored
    run_op(2'd1, 32'h0001_0003, 32'h0002_0005, 5, 1'b0, res);
    check("busy_ignore", res, 64'h0000_0002_000b_000f);
    run_op(2'd1, 32'h0000_0003, 32'h0000_0004, -1, 1'b1, res);
    check("start_wins", res, 64'h0000_0000_0000_000c);
    // Reset aborts a running operation
    run_op(2'd0, 32'hffff_fffd, 32'h0000_0005, -1, 1'b0, res);
    start = 1'b1; op = 2'd1; rs_data = 32'hffff_ffff; rt_data = 32'hffff_ffff;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'h0);
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) bad = 1'b1;
    end
    check("abort_quiet", 64'(bad), 64'd0);
`ifndef MDU_DIV_EN
    rs_data = 32'h5555_0000; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    held = {hi, lo};
    start = 1'b1; op = 2'd2; rs_data = 32'h0000_0064; rt_data = 32'h0000_0007;
    tick();
    start = 1'b0;
    bad = busy;
    repeat (40) begin
      tick();
      if (done || busy) bad = 1'b1;
    end
    check("nodiv_idle", 64'(bad), 64'd0);
    check("nodiv_hilo", {hi, lo}, held);
`endif
    for (int k = 0; k < 30; k++) begin
`ifdef MDU_DIV_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 1));
`endif
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hffff_ffff;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, -1, 1'b0, res);
      check($sformatf("rand%0d op%0d %h %h", k, ro, ra, rb), res, model(ro, ra, rb));
      rs_data = $urandom;
      repeat (2) tick();
      check("hold", {hi, lo}, res);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
